toccata_play_fifo: RTL and testbench
====================================

TOCCATA_PLAY_FIFO -- requirements
Module: toccata_play_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, word entries; power of two, at least 4.
REQ-002 SHALL have clk  input  1  system clock.
REQ-003 SHALL have reset  input  1  synchronous, active-high.
REQ-004 SHALL have clk7_en  input  1  CPU bus qualifier.
REQ-005 SHALL have address_in  input  23  CPU address [23:1].
REQ-006 SHALL have data_in  input  16  CPU write data.
REQ-007 SHALL have rd, hwr, lwr  input  1 each  CPU read, high-byte write, low-byte write strobes.
REQ-008 SHALL have configured  input  1  card autoconfigured (board_configured[4] from the autoconfig block).
REQ-009 SHALL have base_addr  input  8  card base, address bits [23:16] (toccata_base_addr from the autoconfig block).
REQ-010 SHALL have sample_tick  input  1  one-clk pulse per stereo sample period, already synchronous to clk.
REQ-011 SHALL have sel  output  1  card decode.
REQ-012 SHALL have data_out  output  16  register read data.
REQ-013 SHALL have left, right  output  16 each  current stereo sample.
REQ-014 SHALL have irq  output  1  FIFO-low interrupt.

Function
REQ-015 SHALL decode sel = configured AND address_in[23:16]==base_addr; register offset = {address_in[3:1],0}.
REQ-016 SHALL drive data_out = 0 whenever sel=0 or rd=0, or the offset is unmapped.
REQ-017 SHALL accept register writes only in cycles with clk7_en & sel & (hwr|lwr).
REQ-018 SHALL implement offset 0x0 CTRL, read/write low byte: bit0 PLAY, bit1 FLUSH, bit2 IRQEN; FLUSH reads 0.
REQ-019 SHALL empty the FIFO and clear UNDER and OVER in the cycle after FLUSH=1 is written; FLUSH self-clears.
REQ-020 SHALL implement offset 0x2 STATUS, read-only: bit0 EMPTY, bit1 FULL, bit2 LOW (level <= FIFO_DEPTH/2), bit3 UNDER, bit4 OVER, bit15 irq.
REQ-021 SHALL clear UNDER and OVER on any write to offset 0x2.
REQ-022 SHALL push data_in into the FIFO on a write to offset 0x4 only when both hwr and lwr are set; byte writes are ignored.
REQ-023 SHALL drop a push while FULL and set OVER; stored contents stay unchanged.
REQ-024 SHALL make offset 0x6 LEVEL read the entry count, zero-extended.
REQ-025 SHALL run the playback FSM IDLE->POP_L->POP_R->IDLE.
REQ-026 SHALL leave IDLE to POP_L on sample_tick & PLAY when level >= 2.
REQ-027 SHALL, in POP_L, pop the head entry into left; in POP_R, pop the next entry into right; each state lasts one clk.
REQ-028 SHALL, on sample_tick & PLAY with level < 2, set UNDER, pop nothing, and hold left/right.
REQ-029 SHALL ignore sample_tick outside IDLE.
REQ-030 SHALL keep level unchanged when a push and a pop occur in the same cycle, including at full and at empty; the push is accepted when full.
REQ-031 SHALL update left/right exactly 1 clk after the popping state; new samples are visible 2 and 3 clk after the tick.
REQ-032 SHALL let clearing PLAY take effect only from IDLE; an in-flight pair pop completes.
REQ-033 SHALL use read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.

Reset
REQ-034 SHALL, on reset, clear CTRL, flags and pointers; set level=0, FSM=IDLE, left=right=0, irq=0, data_out=0.
REQ-035 SHALL abort any in-progress pop on reset; there is no partial update of right.

Configuration
REQ-036 SHALL, with TOCCATA_IRQ_EN defined, register irq = IRQEN & PLAY & LOW, with 1-clk latency.
REQ-037 SHALL, without TOCCATA_IRQ_EN, tie irq to 0; IRQEN and STATUS bit15 read 0.

Verification
REQ-038 SHALL cover: base=0xE9, configured=1, word writes 0x1111, 0x2222 to 0xE90004, PLAY=1, one tick -> left=0x1111, right=0x2222, LEVEL=0.
REQ-039 SHALL cover: 65 word pushes with depth 64 -> FULL=1, OVER=1, LEVEL=64; after FLUSH -> EMPTY=1, LEVEL=0.
REQ-040 SHALL cover: one entry queued, PLAY=1, tick -> UNDER=1, left/right unchanged, LEVEL=1.
REQ-041 SHALL cover: level=64, a push in the POP_L cycle -> accepted, LEVEL=63 after POP_R, no OVER.
REQ-042 SHALL cover: configured=0, or address 0xEA0004 with base 0xE9 -> sel=0, no push, data_out=0.
REQ-043 SHALL cover, with TOCCATA_IRQ_EN: IRQEN=PLAY=1, level drops 34->32 -> irq=1; a push to 33 -> irq=0.

Source files
------------

// File: rtl/toccata_play_fifo.sv
// Toccata playback FIFO: CPU-written sample FIFO drained in stereo pairs per sample_tick.
// Optional FIFO-low interrupt is built only when TOCCATA_IRQ_EN is defined.
module toccata_play_fifo #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [23:1] address_in,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        hwr,
    input  logic        lwr,
    input  logic        configured,
    input  logic [7:0]  base_addr,
    input  logic        sample_tick,
    output logic        sel,
    output logic [15:0] data_out,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POP_L = 2'd1;
    localparam logic [1:0] ST_POP_R = 2'd2;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] LVL_LOW  = (AW+1)'(FIFO_DEPTH / 2);
    localparam logic [AW:0] LVL_PAIR = (AW+1)'(2);

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [1:0]    state;
    logic          play;
    logic          flush;
    logic          irqen;
    logic          under;
    logic          over;
    logic          irq_r;

    logic [3:0]    offset;
    logic          wr_cyc;
    logic          ctrl_wr;
    logic          push_req;
    logic          pop_req;
    logic          push_ok;
    logic          pop_ok;
    logic          is_empty;
    logic          is_full;
    logic          is_low;
    logic          tick_go;
    logic [15:0]   pop_dat;

    assign sel      = configured && (address_in[23:16] == base_addr);
    assign offset   = {address_in[3:1], 1'b0};
    assign wr_cyc   = clk7_en && sel && (hwr || lwr);
    assign ctrl_wr  = wr_cyc && lwr && (offset == 4'h0);
    assign push_req = wr_cyc && hwr && lwr && (offset == 4'h4);
    assign pop_req  = (state == ST_POP_L) || (state == ST_POP_R);

    assign is_empty = (level == '0);
    assign is_full  = (level == LVL_FULL);
    assign is_low   = (level <= LVL_LOW);

    // A pop frees a slot this cycle, so a push at full still fits; a push at
    // empty feeds a concurrent pop directly.
    assign push_ok  = push_req && (!is_full || pop_req);
    assign pop_ok   = pop_req && (!is_empty || push_req);
    assign pop_dat  = is_empty ? data_in : mem[rd_ptr];
    assign tick_go  = (state == ST_IDLE) && sample_tick && play;

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            play   <= 1'b0;
            flush  <= 1'b0;
            under  <= 1'b0;
            over   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            state  <= ST_IDLE;
            left   <= 16'h0000;
            right  <= 16'h0000;
        end else begin
            if (ctrl_wr) begin
                play  <= data_in[0];
                flush <= data_in[1];
            end else begin
                flush <= 1'b0;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                under  <= 1'b0;
                over   <= 1'b0;
            end else begin
                if (wr_cyc && (offset == 4'h2)) begin
                    under <= 1'b0;
                    over  <= 1'b0;
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
                // Setting after clearing lets a same-cycle event win over a clear.
                if (push_req && !push_ok) begin
                    over <= 1'b1;
                end
                if (tick_go && (level < LVL_PAIR)) begin
                    under <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (tick_go && (level >= LVL_PAIR)) begin
                        state <= ST_POP_L;
                    end
                end
                ST_POP_L: begin
                    state <= ST_POP_R;
                    if (pop_ok && !flush) begin
                        left <= pop_dat;
                    end
                end
                ST_POP_R: begin
                    state <= ST_IDLE;
                    if (pop_ok && !flush) begin
                        right <= pop_dat;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TOCCATA_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irqen <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irqen <= data_in[2];
            end
            irq_r <= irqen && play && is_low;
        end
    end
`else
    assign irqen = 1'b0;
    assign irq_r = 1'b0;
`endif

    assign irq = irq_r;

    always_comb begin
        data_out = 16'h0000;
        if (sel && rd) begin
            case (offset)
                4'h0:    data_out = {13'h0000, irqen, 1'b0, play};
                4'h2:    data_out = {irq_r, 10'h000, over, under, is_low, is_full, is_empty};
                4'h6:    data_out[AW:0] = level;
                default: data_out = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_toccata_play_fifo.sv
// Directed self-checking bench for toccata_play_fifo (depth 64, base 0xE9).
module tb_toccata_play_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic [23:1] address_in;
    logic [15:0] data_in;
    logic        rd;
    logic        hwr;
    logic        lwr;
    logic        configured;
    logic [7:0]  base_addr;
    logic        sample_tick;
    logic        sel;
    logic [15:0] data_out;
    logic [15:0] left;
    logic [15:0] right;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [23:0] A_CTRL   = 24'hE90000;
    localparam logic [23:0] A_STATUS = 24'hE90002;
    localparam logic [23:0] A_DATA   = 24'hE90004;
    localparam logic [23:0] A_LEVEL  = 24'hE90006;

    toccata_play_fifo #(.FIFO_DEPTH(64)) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .address_in(address_in),
        .data_in(data_in), .rd(rd), .hwr(hwr), .lwr(lwr), .configured(configured),
        .base_addr(base_addr), .sample_tick(sample_tick), .sel(sel),
        .data_out(data_out), .left(left), .right(right), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic bus_wr(input logic [23:0] a, input logic [15:0] d,
                          input logic h, input logic l);
        @(negedge clk);
        address_in = a[23:1]; data_in = d; hwr = h; lwr = l; clk7_en = 1'b1;
        @(negedge clk);
        hwr = 1'b0; lwr = 1'b0; clk7_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [23:0] a, output logic [15:0] d);
        @(negedge clk);
        address_in = a[23:1]; rd = 1'b1;
        #1 d = data_out;
        rd = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
    endtask

    task automatic do_flush();
        bus_wr(A_CTRL, 16'h0002, 1'b1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        n_checks++; if (left !== 16'h0 || right !== 16'h0) begin n_fail++; $display("FAIL reset_lr got %h/%h want 0000/0000", left, right); end
        n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", data_out); end
        reset = 1'b0;
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h0005) begin n_fail++; $display("FAIL reset_status got %h want 0005", v); end
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_level got %h want 0000", v); end
        bus_rd(A_CTRL, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl got %h want 0000", v); end
    endtask

    task automatic test_basic_play();
        logic [15:0] v;
        bus_wr(A_DATA, 16'h1111, 1'b1, 1'b1);
        bus_wr(A_DATA, 16'h2222, 1'b1, 1'b1);
        bus_wr(A_CTRL, 16'h0001, 1'b1, 1'b1);
        tick();
        n_checks++; if (left !== 16'h0000 || right !== 16'h0000) begin n_fail++; $display("FAIL play_c1 got %h/%h want 0000/0000", left, right); end
        @(negedge clk);
        n_checks++; if (left !== 16'h1111 || right !== 16'h0000) begin n_fail++; $display("FAIL play_c2 got %h/%h want 1111/0000", left, right); end
        @(negedge clk);
        n_checks++; if (right !== 16'h2222) begin n_fail++; $display("FAIL play_c3_right got %h want 2222", right); end
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL play_level got %h want 0000", v); end
    endtask

    task automatic test_tick_busy();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) bus_wr(A_DATA, 16'hA001 + 16'(i), 1'b1, 1'b1);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk); sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h0002) begin n_fail++; $display("FAIL busy_level got %h want 0002", v); end
        n_checks++; if (left !== 16'hA001 || right !== 16'hA002) begin n_fail++; $display("FAIL busy_lr got %h/%h want a001/a002", left, right); end
        do_flush();
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        for (int i = 0; i < 65; i++) bus_wr(A_DATA, 16'h0100 + 16'(i), 1'b1, 1'b1);
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h0012) begin n_fail++; $display("FAIL ovf_status got %h want 0012", v); end
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h0040) begin n_fail++; $display("FAIL ovf_level got %h want 0040", v); end
        bus_wr(A_CTRL, 16'h0001, 1'b1, 1'b1);
        tick();
        repeat (2) @(negedge clk);
        n_checks++; if (left !== 16'h0100 || right !== 16'h0101) begin n_fail++; $display("FAIL ovf_contents got %h/%h want 0100/0101", left, right); end
        do_flush();
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h0005) begin n_fail++; $display("FAIL flush_status got %h want 0005", v); end
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL flush_level got %h want 0000", v); end
        bus_rd(A_CTRL, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL flush_ctrl got %h want 0000", v); end
    endtask

    task automatic test_underflow();
        logic [15:0] v;
        bus_wr(A_CTRL, 16'h0001, 1'b1, 1'b1);
        bus_wr(A_DATA, 16'h3333, 1'b1, 1'b1);
        tick();
        repeat (3) @(negedge clk);
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h000C) begin n_fail++; $display("FAIL under_status got %h want 000c", v); end
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h0001) begin n_fail++; $display("FAIL under_level got %h want 0001", v); end
        n_checks++; if (left !== 16'h0100 || right !== 16'h0101) begin n_fail++; $display("FAIL under_lr got %h/%h want 0100/0101", left, right); end
        bus_wr(A_STATUS, 16'h0000, 1'b1, 1'b1);
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h0004) begin n_fail++; $display("FAIL under_clear got %h want 0004", v); end
        do_flush();
    endtask

    task automatic test_full_push_pop();
        logic [15:0] v;
        for (int i = 0; i < 64; i++) bus_wr(A_DATA, 16'h4000 + 16'(i), 1'b1, 1'b1);
        bus_wr(A_CTRL, 16'h0001, 1'b1, 1'b1);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        address_in = A_DATA[23:1]; data_in = 16'h5555; hwr = 1'b1; lwr = 1'b1; clk7_en = 1'b1;
        @(negedge clk);
        hwr = 1'b0; lwr = 1'b0; clk7_en = 1'b0;
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h003F) begin n_fail++; $display("FAIL fullpp_level got %h want 003f", v); end
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL fullpp_status got %h want 0000", v); end
        n_checks++; if (left !== 16'h4000 || right !== 16'h4001) begin n_fail++; $display("FAIL fullpp_lr got %h/%h want 4000/4001", left, right); end
        do_flush();
    endtask

    task automatic test_decode();
        logic [15:0] v;
        @(negedge clk);
        configured = 1'b0;
        address_in = A_DATA[23:1]; data_in = 16'hDEAD; hwr = 1'b1; lwr = 1'b1; clk7_en = 1'b1; rd = 1'b0;
        #1;
        n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL dec_unconf_sel got %b want 0", sel); end
        @(negedge clk);
        hwr = 1'b0; lwr = 1'b0; clk7_en = 1'b0;
        address_in = A_STATUS[23:1]; rd = 1'b1;
        #1;
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL dec_unconf_dout got %h want 0000", data_out); end
        rd = 1'b0;
        configured = 1'b1;
        @(negedge clk);
        address_in = 23'h750002; data_in = 16'hBEEF; hwr = 1'b1; lwr = 1'b1; clk7_en = 1'b1;
        #1;
        n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL dec_base_sel got %b want 0", sel); end
        @(negedge clk);
        hwr = 1'b0; lwr = 1'b0; clk7_en = 1'b0;
        address_in = 23'h750001; rd = 1'b1;
        #1;
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL dec_base_dout got %h want 0000", data_out); end
        rd = 1'b0;
        bus_wr(A_DATA, 16'hCAFE, 1'b1, 1'b0);
        bus_rd(A_LEVEL, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL dec_level got %h want 0000", v); end
        bus_rd(24'hE90008, v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL dec_unmapped got %h want 0000", v); end
        @(negedge clk);
        address_in = A_STATUS[23:1]; rd = 1'b0;
        #1;
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL dec_nord got %h want 0000", data_out); end
    endtask

    task automatic test_irq();
        logic [15:0] v;
`ifdef TOCCATA_IRQ_EN
        for (int i = 0; i < 34; i++) bus_wr(A_DATA, 16'h6000 + 16'(i), 1'b1, 1'b1);
        bus_wr(A_CTRL, 16'h0005, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_l34 got %b want 0", irq); end
        tick();
        repeat (3) @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_l32 got %b want 1", irq); end
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h8004) begin n_fail++; $display("FAIL irq_status got %h want 8004", v); end
        bus_wr(A_DATA, 16'h7777, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_l33 got %b want 0", irq); end
`else
        bus_wr(A_CTRL, 16'h0005, 1'b1, 1'b1);
        bus_rd(A_CTRL, v);
        n_checks++; if (v !== 16'h0001) begin n_fail++; $display("FAIL noirq_ctrl got %h want 0001", v); end
        repeat (2) @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL noirq_irq got %b want 0", irq); end
        bus_rd(A_STATUS, v);
        n_checks++; if (v !== 16'h0005) begin n_fail++; $display("FAIL noirq_status got %h want 0005", v); end
`endif
        do_flush();
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b0; address_in = '0; data_in = 16'h0;
        rd = 1'b0; hwr = 1'b0; lwr = 1'b0; configured = 1'b1;
        base_addr = 8'hE9; sample_tick = 1'b0;
        test_reset();
        test_basic_play();
        test_tick_busy();
        test_overflow();
        test_underflow();
        test_full_push_pop();
        test_decode();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
